// File: rtl/axi_lite_regs_slave.sv
// axi_lite_regs_slave
//   AXI4-Lite responder with four 32-bit word registers that drive the
//   Mandelbrot core's control inputs.
//
//   0x0 DATA_0  RW
//   0x4 DATA_1  RW
//   0x8 CTRL    RW  bit0 start (write-only, reads 0), bit1 enable
//   0xC STATUS  RO  [15:0] accepted writes, [31:16] accepted reads
//
//   Optional build macro: AXI_SLVERR_EN
//     defined   - a write to STATUS answers SLVERR (2'b10)
//     undefined - a write to STATUS answers OKAY and is ignored
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn   clock, async active-low reset
//   s00_axi_aw* / w* / b*            write address, data, response channels
//   s00_axi_ar* / r*                 read address, data channels
//   data_0_o, data_1_o               DATA_0 / DATA_1 contents
//   enable_o                         CTRL bit 1
//   start_o                          one-cycle pulse on CTRL write with bit 0 = 1
module axi_lite_regs_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   data_0_o,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   data_1_o,
  output logic                              enable_o,
  output logic                              start_o
);

`ifdef AXI_SLVERR_EN
  localparam logic [1:0] STATUS_WR_RESP = 2'b10;
`else
  localparam logic [1:0] STATUS_WR_RESP = 2'b00;
`endif

  logic        aw_held, w_held;
  logic [1:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic [31:0] data_0_q, data_1_q;
  logic        enable_q, start_q;
  logic [15:0] wr_cnt, rd_cnt;

  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic aw_hs, w_hs, ar_hs, commit;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Readies are gated by reset so they read 0 while reset is held.
  assign s00_axi_awready = s00_axi_aresetn & ~aw_held & ~bvalid_q;
  assign s00_axi_wready  = s00_axi_aresetn & ~w_held  & ~bvalid_q;
  assign s00_axi_arready = s00_axi_aresetn & ~rvalid_q;

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid  & s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign commit = aw_held & w_held & ~bvalid_q;

  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign s00_axi_rresp  = 2'b00;

  assign data_0_o = data_0_q;
  assign data_1_o = data_1_q;
  assign enable_o = enable_q;
  assign start_o  = start_q;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] d,
                                             input logic [3:0]  s);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    rd_mux = 32'h0;
    case (s00_axi_araddr[3:2])
      2'd0:    rd_mux = data_0_q;
      2'd1:    rd_mux = data_1_q;
      2'd2:    rd_mux = {30'd0, enable_q, 1'b0};
      default: rd_mux = {rd_cnt, wr_cnt};
    endcase
  end

  // Write path: AW and W are captured independently; the write commits
  // one edge after the later of the two handshakes.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= 2'd0;
      w_data   <= 32'h0;
      w_strb   <= 4'h0;
      data_0_q <= 32'h0;
      data_1_q <= 32'h0;
      enable_q <= 1'b0;
      start_q  <= 1'b0;
      wr_cnt   <= 16'h0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      start_q <= 1'b0;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s00_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        wr_cnt   <= wr_cnt + 16'd1;
        bresp_q  <= (aw_idx == 2'd3) ? STATUS_WR_RESP : 2'b00;
        case (aw_idx)
          2'd0: data_0_q <= apply_strb(data_0_q, w_data, w_strb);
          2'd1: data_1_q <= apply_strb(data_1_q, w_data, w_strb);
          2'd2: begin
            // Only byte lane 0 carries CTRL bits.
            if (w_strb[0]) begin
              enable_q <= w_data[1];
              start_q  <= w_data[0];
            end
          end
          default: ;
        endcase
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read path: data is sampled on the AR handshake edge, so a same-edge
  // write commit is seen only by later reads.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      rd_cnt   <= 16'h0;
    end else begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
        rd_cnt   <= rd_cnt + 16'd1;
      end else if (rvalid_q && s00_axi_rready) begin
        rvalid_q <= 1'b0;
        rdata_q  <= 32'h0;
      end
    end
  end

endmodule
